// File: rtl/wb_spi_sram.sv
// Wishbone memory slave that turns 32-bit cycles into SPI mode-0 READ/WRITE frames
// to an external serial SRAM, and returns its own single-cycle ack.
module wb_spi_sram #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DIV       = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_spi_sclk,
  output logic        o_spi_cs_n,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DivLast = DW'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone, StGap} state_e;

  state_e        state_q, state_d;
  logic [63:0]   tx_q, tx_d;
  logic [31:0]   rx_q, rx_d;
  logic [31:0]   rdt_q, rdt_d;
  logic [6:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    nbits_q, nbits_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          we_q, we_d;

  // Frame image for the request currently on the bus, left-justified in 64 bits.
  logic [1:0]  first_lane;
  logic [2:0]  nbytes;
  logic [31:0] wdata;
  logic [23:0] addr_v;
  logic [7:0]  cmd;
  logic [63:0] frame;

  logic unused_adr;
  assign unused_adr = ^{i_wb_adr[31:ADDR_BITS], i_wb_adr[1:0]};

  always_comb begin
    int unsigned idx;
    logic        found;
    first_lane = 2'b00;
    found      = 1'b0;
    wdata      = 32'h0;
    idx        = 0;
    for (int k = 0; k < 4; k++) begin
      if (i_wb_sel[k]) begin
        if (!found) begin
          first_lane = 2'(k);
          found      = 1'b1;
        end
        wdata = wdata | ({24'h0, i_wb_dat[8*k +: 8]} << (24 - 8 * idx));
        idx   = idx + 1;
      end
    end
    if (i_wb_we) begin
      nbytes = 3'(idx);
      cmd    = 8'h02;
      addr_v = 24'({i_wb_adr[ADDR_BITS-1:2], first_lane});
    end else begin
      nbytes = 3'd4;
      cmd    = 8'h03;
      wdata  = 32'h0;
      addr_v = 24'({i_wb_adr[ADDR_BITS-1:2], 2'b00});
    end
    frame = {cmd, 56'h0}
          | (64'(addr_v) << (56 - ADDR_BITS))
          | (64'(wdata) << (24 - ADDR_BITS));
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rdt_d     = rdt_q;
    bit_cnt_d = bit_cnt_q;
    nbits_d   = nbits_q;
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    we_d      = we_q;

    unique case (state_q)
      StIdle: begin
        if (i_wb_cyc) begin
          we_d = i_wb_we;
          if (i_wb_we && (i_wb_sel == 4'b0000)) begin
            state_d = StDone;
          end else begin
            state_d   = StShift;
            mosi_d    = frame[63];
            tx_d      = frame << 1;
            nbits_d   = 7'(8 + ADDR_BITS + 8 * 32'(nbytes));
            bit_cnt_d = 7'd0;
            div_cnt_d = '0;
            sclk_d    = 1'b0;
          end
        end
      end
      StShift: begin
        if (div_cnt_q == DivLast) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[30:0], i_spi_miso};
          end else if (bit_cnt_q == nbits_q - 7'd1) begin
            state_d = StDone;
            sclk_d  = 1'b0;
            if (!we_q) begin
              // First byte on the wire is the lowest-addressed byte.
              rdt_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
            end
          end else begin
            sclk_d    = 1'b0;
            mosi_d    = tx_q[63];
            tx_d      = tx_q << 1;
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      StDone: begin
        state_d   = StGap;
        div_cnt_d = '0;
        mosi_d    = 1'b0;
      end
      StGap: begin
        if (div_cnt_q == DivLast) begin
          state_d = StIdle;
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      tx_q      <= '0;
      rx_q      <= '0;
      rdt_q     <= '0;
      bit_cnt_q <= '0;
      nbits_q   <= '0;
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rdt_q     <= rdt_d;
      bit_cnt_q <= bit_cnt_d;
      nbits_q   <= nbits_d;
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      we_q      <= we_d;
    end
  end

  assign o_spi_cs_n = (state_q != StShift);
  assign o_wb_ack   = (state_q == StDone);
  assign o_spi_sclk = sclk_q;
  assign o_spi_mosi = mosi_q;
  assign o_wb_rdt   = rdt_q;

endmodule

// File: tb/tb_wb_spi_sram.sv
// Bench for wb_spi_sram: two instances (DIV=1, DIV=2) sharing a behavioural serial SRAM
// and a spec-level reference model of frames, latency, read data and memory contents.
module tb_wb_spi_sram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, cyc;
  int          dsel;
  logic        miso;

  logic cyc1, cyc2;
  logic [31:0] rdt1, rdt2;
  logic ack1, ack2, sclk1, sclk2, cs1, cs2, mosi1, mosi2;

  assign cyc1 = cyc && (dsel == 0);
  assign cyc2 = cyc && (dsel == 1);

  wb_spi_sram #(.ADDR_BITS(16), .DIV(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc1), .o_wb_rdt(rdt1), .o_wb_ack(ack1),
    .o_spi_sclk(sclk1), .o_spi_cs_n(cs1), .o_spi_mosi(mosi1), .i_spi_miso(miso)
  );

  wb_spi_sram #(.ADDR_BITS(16), .DIV(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc2), .o_wb_rdt(rdt2), .o_wb_ack(ack2),
    .o_spi_sclk(sclk2), .o_spi_cs_n(cs2), .o_spi_mosi(mosi2), .i_spi_miso(miso)
  );

  logic        m_sclk, m_cs_n, m_mosi, m_ack;
  logic [31:0] m_rdt;
  assign m_sclk = (dsel == 1) ? sclk2 : sclk1;
  assign m_cs_n = (dsel == 1) ? cs2 : cs1;
  assign m_mosi = (dsel == 1) ? mosi2 : mosi1;
  assign m_ack  = (dsel == 1) ? ack2 : ack1;
  assign m_rdt  = (dsel == 1) ? rdt2 : rdt1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Serial SRAM model: decodes cmd/address from received bits, serves reads, commits writes.
  logic [7:0] mem     [65536];
  logic [7:0] ref_mem [65536];
  bit         bitq[$];
  bit         last_frame[$];
  int         frames = 0;
  int         rd_idx, rd_addr, wr_addr;

  function automatic int qval(input int start, input int len);
    int v = 0;
    for (int i = 0; i < len; i++) v = (v << 1) | int'(bitq[start + i]);
    return v;
  endfunction

  always @(negedge m_cs_n) begin
    bitq.delete();
    miso = 1'b0;
  end

  always @(posedge m_sclk) if (m_cs_n === 1'b0) bitq.push_back(m_mosi);

  always @(negedge m_sclk) begin
    if (m_cs_n === 1'b0 && bitq.size() >= 24 && qval(0, 8) == 8'h03) begin
      rd_idx  = bitq.size() - 24;
      rd_addr = qval(8, 16) + rd_idx / 8;
      miso    = mem[16'(rd_addr)][7 - rd_idx % 8];
    end
  end

  always @(posedge m_cs_n) begin
    last_frame = bitq;
    frames++;
    if (bitq.size() >= 24 && qval(0, 8) == 8'h02) begin
      wr_addr = qval(8, 16);
      for (int i = 0; i < (bitq.size() - 24) / 8; i++)
        mem[16'(wr_addr + i)] = 8'(qval(24 + 8 * i, 8));
    end
  end

  // Reference model derived from the frame rules.
  bit          exp_bits[$];
  logic [31:0] last_rdt[2];

  function automatic int nbytes_of(input bit twe, input logic [3:0] tsel);
    int n = 0;
    if (!twe) return 4;
    for (int k = 0; k < 4; k++) if (tsel[k]) n++;
    return n;
  endfunction

  function automatic int first_of(input logic [3:0] tsel);
    for (int k = 0; k < 4; k++) if (tsel[k]) return k;
    return 0;
  endfunction

  function automatic int model_lat(input bit twe, input logic [3:0] tsel, input int div);
    if (twe && tsel == 4'b0000) return 1;
    return (24 + 8 * nbytes_of(twe, tsel)) * 2 * div + 1;
  endfunction

  function automatic logic [31:0] model_rdt(input logic [31:0] tadr);
    int a = int'({tadr[15:2], 2'b00});
    return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
  endfunction

  task automatic build_exp(input bit twe, input logic [31:0] tadr, input logic [31:0] tdat,
                           input logic [3:0] tsel);
    logic [7:0]  c = twe ? 8'h02 : 8'h03;
    int          f = twe ? first_of(tsel) : 0;
    logic [15:0] a = {tadr[15:2], 2'(f)};
    exp_bits.delete();
    for (int i = 7; i >= 0; i--) exp_bits.push_back(c[i]);
    for (int i = 15; i >= 0; i--) exp_bits.push_back(a[i]);
    if (twe)
      for (int k = 0; k < 4; k++)
        if (tsel[k]) for (int i = 7; i >= 0; i--) exp_bits.push_back(tdat[8 * k + i]);
  endtask

  task automatic do_txn(input string tag, input bit twe, input logic [31:0] tadr,
                        input logic [31:0] tdat, input logic [3:0] tsel,
                        input int exp_lat, input logic [31:0] exp_rdt);
    int k = 0;
    bit got = 0;
    int f0 = frames;
    int nb = nbytes_of(twe, tsel);
    int bad = 0;
    int base;
    build_exp(twe, tadr, tdat, tsel);
    @(negedge clk);
    we = twe; adr = tadr; dat = tdat; sel = tsel; cyc = 1'b1;
    while (k < 4000) begin
      @(negedge clk);
      k++;
      if (m_ack === 1'b1) begin
        got = 1;
        break;
      end
    end
    cyc = 1'b0;
    check({tag, " latency"}, got ? 64'(k) : 64'hFFFF, 64'(exp_lat));
    check({tag, " rdt"}, m_rdt, exp_rdt);
    if (twe && tsel == 4'b0000) begin
      check({tag, " no frame"}, 64'(frames - f0), 64'd0);
    end else begin
      check({tag, " frame count"}, 64'(frames - f0), 64'd1);
      check({tag, " frame bits"}, 64'(last_frame.size()), 64'(24 + 8 * nb));
      for (int i = 0; i < exp_bits.size(); i++)
        if (i >= last_frame.size() || last_frame[i] != exp_bits[i]) bad++;
      check({tag, " mosi content errors"}, 64'(bad), 64'd0);
    end
    @(negedge clk);
    check({tag, " ack single pulse"}, 64'(m_ack), 64'd0);
    if (twe) begin
      base = int'(tadr[15:0]);
      for (int kk = 0; kk < 4; kk++)
        if (tsel[kk]) begin
          ref_mem[16'(base - int'(tadr[1:0]) + kk)] = tdat[8 * kk +: 8];
          check({tag, " sram byte"}, 64'(mem[16'(base - int'(tadr[1:0]) + kk)]),
                64'(tdat[8 * kk +: 8]));
        end
    end else begin
      last_rdt[dsel] = exp_rdt;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic b2b(input int which);
    int div = which + 1;
    int acks[$];
    int f0 = frames;
    int run = 0, min_run = 1000;
    bit seen_low = 0;
    int lat = 56 * 2 * div + 1;
    logic cs_after_ack = 1'b0;
    dsel = which;
    @(negedge clk);
    we = 1'b0; adr = 32'h0000_1236; sel = 4'hF; cyc = 1'b1;
    for (int c = 1; c <= 1500; c++) begin
      @(negedge clk);
      if (m_ack === 1'b1) begin
        acks.push_back(c);
        if (acks.size() == 2) cyc = 1'b0;
      end
      if (acks.size() == 1 && c == acks[0] + 1) cs_after_ack = m_cs_n;
      if (m_cs_n === 1'b0) begin
        if (seen_low && run > 0 && run < min_run) min_run = run;
        seen_low = 1;
        run = 0;
      end else if (seen_low) begin
        run++;
      end
      if (acks.size() == 2 && c > acks[1] + 20) break;
    end
    cyc = 1'b0;
    check($sformatf("b2b div%0d ack count", div), 64'(acks.size()), 64'd2);
    check($sformatf("b2b div%0d frames", div), 64'(frames - f0), 64'd2);
    if (acks.size() == 2) begin
      check($sformatf("b2b div%0d first ack", div), 64'(acks[0]), 64'(lat));
      check($sformatf("b2b div%0d second ack", div), 64'(acks[1]), 64'(2 * lat + div + 1));
    end
    check($sformatf("b2b div%0d cs high after ack", div), 64'(cs_after_ack), 64'd1);
    check($sformatf("b2b div%0d min cs high", div), 64'(min_run >= div + 1), 64'd1);
    last_rdt[which] = model_rdt(32'h0000_1236);
    check($sformatf("b2b div%0d rdt", div), m_rdt, last_rdt[which]);
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          lat;
    logic [31:0] rdt;
  } vec_t;

  vec_t vecs[6];
  logic [3:0] pats[11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [3:0] rs;
    logic [31:0] ra, rd;
    bit rw;

    vecs[0] = '{1'b0, 32'h0000_1236, 32'h0,         4'hF,    113, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0040, 32'h1122_3344, 4'b1111, 113, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0100, 32'hAABB_CCDD, 4'b0100, 65,  32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 32'h0000_0200, 32'hAABB_CCDD, 4'b0110, 81,  32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 32'h0000_0300, 32'h1234_5678, 4'b0000, 1,   32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 32'hFFFF_0042, 32'h0,         4'h0,    113, 32'h1122_3344};
    pats = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'h7, 4'hE, 4'hF};

    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[16'h1234] = 8'hEF; mem[16'h1235] = 8'hBE; mem[16'h1236] = 8'hAD; mem[16'h1237] = 8'hDE;
    for (int i = 0; i < 4; i++) ref_mem[16'h1234 + i] = mem[16'h1234 + i];

    rst = 1'b1; cyc = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0; dsel = 0; miso = 1'b0;
    repeat (3) @(negedge clk);
    check("reset cs1", 64'(cs1), 64'd1);
    check("reset sclk1", 64'(sclk1), 64'd0);
    check("reset mosi1", 64'(mosi1), 64'd0);
    check("reset ack1", 64'(ack1), 64'd0);
    check("reset rdt1", rdt1, 64'd0);
    check("reset cs2/ack2/rdt2", {cs2, ack2, sclk2, rdt2}, {3'b100, 32'h0});
    rst = 1'b0;
    last_rdt[0] = '0;
    last_rdt[1] = '0;

    for (int i = 0; i < 6; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
             vecs[i].lat, vecs[i].rdt);

    // Reset during the address phase of a read, then a fresh frame.
    @(negedge clk);
    we = 1'b0; adr = 32'h0000_1234; sel = 4'hF; cyc = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1; cyc = 1'b0;
    @(negedge clk);
    check("midreset cs_n", 64'(cs1), 64'd1);
    check("midreset sclk", 64'(sclk1), 64'd0);
    check("midreset ack", 64'(ack1), 64'd0);
    check("midreset rdt", rdt1, 64'd0);
    rst = 1'b0;
    last_rdt[0] = '0;
    last_rdt[1] = '0;
    do_txn("post-reset read", 1'b0, 32'h0000_1236, 32'h0, 4'hF, 113, 32'hDEAD_BEEF);

    b2b(1);
    b2b(0);

    for (int r = 0; r < 40; r++) begin
      dsel = (r >= 30) ? 1 : 0;
      rw = 1'($urandom);
      rs = pats[$urandom_range(0, 10)];
      ra = $urandom;
      rd = $urandom;
      do_txn($sformatf("rand%0d", r), rw, ra, rd, rs, model_lat(rw, rs, dsel + 1),
             rw ? last_rdt[dsel] : model_rdt(ra));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
